// File: rtl/eeprom_access_arbiter.sv
// eeprom_access_arbiter: round-robin two-port sequencer in front of the I2C EEPROM engine.
// Define EEPROM_ARB_TIMEOUT_EN to add the engine watchdog in WAIT.
module eeprom_access_arbiter #(
  parameter logic [6:0] DEV_ADDR       = 7'h50,
  parameter int         WR_GAP_CYCLES  = 500,
  parameter int         TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req0,
  input  logic       req1,
  input  logic       we0,
  input  logic       we1,
  input  logic [3:0] addr0,
  input  logic [3:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] rdata,
  output logic       err,
  output logic       busy,
  output logic [7:0] eng_i2c_addr,
  output logic [3:0] eng_word_addr,
  output logic [7:0] eng_wr_data,
  output logic       eng_go,
  input  logic       eng_done,
  input  logic [7:0] eng_rd_data,
  input  logic       eng_nack
);
  localparam int CNT_MAX = WR_GAP_CYCLES > TIMEOUT_CYCLES ? WR_GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, GAP, RESP} state_t;
  state_t state, next;

  logic pri, port, rd, gnt, start, timeout, count;
  logic [CW-1:0] cnt;

  assign start = state == IDLE && (req0 || req1);
  assign gnt   = (req0 && req1) ? pri : req1;

  // One counter serves both the write gap and the watchdog; they never overlap.
`ifdef EEPROM_ARB_TIMEOUT_EN
  assign timeout = state == WAIT && !eng_done && cnt == CW'(TIMEOUT_CYCLES - 1);
  assign count   = state == GAP || state == WAIT;
`else
  assign timeout = 1'b0;
  assign count   = state == GAP;
`endif

  always_comb begin
    next = state;
    case (state)
      IDLE:    next = start ? ISSUE : IDLE;
      ISSUE:   next = WAIT;
      WAIT:    next = eng_done ? ((!rd && !eng_nack) ? GAP : RESP) : (timeout ? RESP : WAIT);
      GAP:     next = cnt == CW'(WR_GAP_CYCLES - 1) ? RESP : GAP;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pri           <= 1'b0;
      port          <= 1'b0;
      rd            <= 1'b0;
      eng_word_addr <= '0;
      eng_wr_data   <= '0;
      rdata         <= '0;
      err           <= 1'b0;
      cnt           <= '0;
    end else begin
      cnt <= (count && next == state) ? cnt + 1'b1 : '0;
      if (start) begin
        port          <= gnt;
        pri           <= !gnt;
        rd            <= gnt ? !we1 : !we0;
        eng_word_addr <= gnt ? addr1 : addr0;
        eng_wr_data   <= gnt ? wdata1 : wdata0;
      end
      if (state == WAIT && eng_done) begin
        err <= eng_nack;
        if (rd) rdata <= eng_rd_data;
      end else if (timeout) begin
        err <= 1'b1;
      end
    end
  end

  assign ack0         = state == RESP && !port;
  assign ack1         = state == RESP && port;
  assign busy         = state != IDLE;
  assign eng_go       = state == ISSUE;
  assign eng_i2c_addr = {DEV_ADDR, rd};
endmodule

// File: tb/tb_eeprom_access_arbiter.sv
// tb_eeprom_access_arbiter: directed stimulus with a timestamp-based model of the arbiter.
module tb_eeprom_access_arbiter;
  localparam int GAP = 8;
  localparam int TO  = 16;

  logic       clk = 0, reset_n = 0;
  logic       req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [3:0] addr0 = 0, addr1 = 0;
  logic [7:0] wdata0 = 0, wdata1 = 0;
  logic       ack0, ack1, err, busy, eng_go;
  logic [7:0] rdata, eng_i2c_addr, eng_wr_data;
  logic [3:0] eng_word_addr;
  logic       eng_done = 0, eng_nack = 0;
  logic [7:0] eng_rd_data = 0;

  eeprom_access_arbiter #(.DEV_ADDR(7'h50), .WR_GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err), .busy(busy),
    .eng_i2c_addr(eng_i2c_addr), .eng_word_addr(eng_word_addr), .eng_wr_data(eng_wr_data),
    .eng_go(eng_go), .eng_done(eng_done), .eng_rd_data(eng_rd_data), .eng_nack(eng_nack)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, e = 0;

  int left0 = 0, left1 = 0, eng_wait = -1, resp_delay = 0;
  logic resp_en = 1, resp_nack = 0, stray = 0;
  logic [7:0] resp_data = 0;

  int n_ack = 0, n_go = 0, go_cyc = 0, done_cyc = 0, ack_cyc = 0;
  int order [16];
  logic [7:0] go_i2c = 0, go_wd = 0, ack_rd = 0;
  logic [3:0] go_word = 0;
  logic ack_err = 0;

  logic s_rstn, s_req0, s_req1, s_we0, s_we1, s_done, s_nack;
  logic [3:0] s_addr0, s_addr1;
  logic [7:0] s_wd0, s_wd1, s_rdata;

  // Model: a transaction is a grant edge plus the edge at which its ACK appears.
  logic active = 0, fresh = 1, pri = 0, m_port = 0, m_rd = 0, m_err = 0;
  logic [7:0] m_rdata = 0, m_wd = 0;
  logic [3:0] m_addr = 0;
  int t_grant = 0, ack_edge = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, e);
    end
  endtask

  task automatic model_step();
    logic g;
    if (!s_rstn) begin
      active = 0; pri = 0; m_rdata = 0; m_err = 0; fresh = 1; ack_edge = -1;
    end else if (active && e == ack_edge + 1) begin
      active = 0;
    end else if (!active) begin
      if (s_req0 || s_req1) begin
        g = (s_req0 && s_req1) ? pri : s_req1;
        pri = !g; m_port = g;
        m_rd = g ? !s_we1 : !s_we0;
        m_addr = g ? s_addr1 : s_addr0;
        m_wd = g ? s_wd1 : s_wd0;
        t_grant = e; ack_edge = -1; active = 1; fresh = 0;
      end
    end else if (ack_edge < 0) begin
      if (s_done && e >= t_grant + 2) begin
        m_err = s_nack;
        if (m_rd) m_rdata = s_rdata;
        ack_edge = e + ((!m_rd && !s_nack) ? GAP : 0);
      end
`ifdef EEPROM_ARB_TIMEOUT_EN
      else if (e == t_grant + 1 + TO) begin
        m_err = 1; ack_edge = e;
      end
`endif
    end
  endtask

  task automatic compare();
    chk("busy", busy, active);
    chk("eng_go", eng_go, active && e == t_grant);
    chk("ack0", ack0, active && e == ack_edge && !m_port);
    chk("ack1", ack1, active && e == ack_edge && m_port);
    chk("rdata", rdata, m_rdata);
    chk("single_ack", ack0 & ack1, 0);
    if (active && e == ack_edge) chk("err", err, m_err);
    if (active) begin
      chk("i2c_addr", eng_i2c_addr, {7'h50, m_rd});
      chk("word_addr", eng_word_addr, m_addr);
      chk("wr_data", eng_wr_data, m_wd);
    end
    if (fresh) begin
      chk("i2c_addr_rst", eng_i2c_addr, 8'hA0);
      chk("word_addr_rst", eng_word_addr, 0);
      chk("wr_data_rst", eng_wr_data, 0);
      chk("err_rst", err, 0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    s_rstn = reset_n; s_req0 = req0; s_req1 = req1; s_we0 = we0; s_we1 = we1;
    s_addr0 = addr0; s_addr1 = addr1; s_wd0 = wdata0; s_wd1 = wdata1;
    s_done = eng_done; s_nack = eng_nack; s_rdata = eng_rd_data;
    @(negedge clk);
    e++;
    model_step();
    compare();
    if (eng_go) begin
      n_go++; go_cyc = e; go_i2c = eng_i2c_addr; go_word = eng_word_addr; go_wd = eng_wr_data;
    end
    if (s_done) done_cyc = e - 1;
    if (ack0 || ack1) begin
      ack_cyc = e; ack_rd = rdata; ack_err = err;
      if (n_ack < 16) order[n_ack] = int'(ack1);
      n_ack++;
      if (ack0 && left0 > 0) left0--;
      if (ack1 && left1 > 0) left1--;
    end
    eng_done = 0; eng_nack = 0;
    if (eng_go && resp_en) eng_wait = resp_delay + 1;
    if (eng_wait == 0) begin
      eng_done = 1; eng_nack = resp_nack; eng_rd_data = resp_data;
    end
    if (eng_wait >= 0) eng_wait--;
    if (stray) begin
      eng_done = 1; stray = 0;
    end
    req0 = left0 > 0;
    req1 = left1 > 0;
  endtask

  task automatic wait_acks(input int target, input int budget);
    int k = 0;
    while (n_ack < target && k < budget) begin
      tick();
      k++;
    end
    chk("ack_count", n_ack, target);
  endtask

  initial begin
    repeat (3) tick();
    reset_n = 1;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_i2c", eng_i2c_addr, 8'hA0);
    chk("rst_rdata", rdata, 8'h00);

    we0 = 0; addr0 = 4'h3; resp_data = 8'h55; resp_nack = 0; resp_delay = 2;
    left0 = 1; req0 = 1;
    wait_acks(1, 100);
    chk("t1_go_count", n_go, 1);
    chk("t1_i2c", go_i2c, 8'hA1);
    chk("t1_word", go_word, 4'h3);
    chk("t1_rdata", ack_rd, 8'h55);
    chk("t1_err", ack_err, 0);
    chk("t1_port", order[0], 0);
    chk("t1_latency", ack_cyc - done_cyc, 1);

    we1 = 1; addr1 = 4'h7; wdata1 = 8'hAA; resp_delay = 0;
    left1 = 1; req1 = 1;
    wait_acks(2, 100);
    chk("t2_i2c", go_i2c, 8'hA0);
    chk("t2_wdata", go_wd, 8'hAA);
    chk("t2_word", go_word, 4'h7);
    chk("t2_latency", ack_cyc - done_cyc, 9);
    chk("t2_go_to_ack", ack_cyc - go_cyc, 10);
    chk("t2_port", order[1], 1);
    chk("t2_err", ack_err, 0);
    repeat (2) tick();

    we0 = 0; addr0 = 4'h1; we1 = 1; addr1 = 4'h2; wdata1 = 8'h3C;
    resp_data = 8'h96; resp_delay = 1;
    left0 = 2; left1 = 2; req0 = 1; req1 = 1;
    wait_acks(6, 300);
    chk("rr_0", order[2], 0);
    chk("rr_1", order[3], 1);
    chk("rr_2", order[4], 0);
    chk("rr_3", order[5], 1);

    we0 = 1; addr0 = 4'h9; wdata0 = 8'h5A; resp_nack = 1; resp_delay = 3;
    left0 = 1; req0 = 1;
    wait_acks(7, 100);
    chk("nack_latency", ack_cyc - done_cyc, 1);
    chk("nack_err", ack_err, 1);
    chk("nack_port", order[6], 0);
    resp_nack = 0;

    tick();
    stray = 1;
    repeat (3) tick();
    chk("stray_busy", busy, 0);
    chk("stray_acks", n_ack, 7);

    resp_en = 0; we0 = 0; addr0 = 4'hC; left0 = 1; req0 = 1;
    repeat (6) tick();
    chk("abort_busy_before", busy, 1);
    left0 = 0; req0 = 0; reset_n = 0;
    repeat (2) tick();
    chk("abort_busy", busy, 0);
    chk("abort_go", eng_go, 0);
    chk("abort_ack0", ack0, 0);
    chk("abort_i2c", eng_i2c_addr, 8'hA0);
    chk("abort_rdata", rdata, 8'h00);
    chk("abort_err", err, 0);
    chk("abort_acks", n_ack, 7);
    reset_n = 1; resp_en = 1; resp_data = 8'hC3; resp_delay = 0;
    left0 = 1; req0 = 1;
    wait_acks(8, 100);
    chk("retry_rdata", ack_rd, 8'hC3);
    chk("retry_port", order[7], 0);
    chk("retry_err", ack_err, 0);

    resp_en = 0; we1 = 0; addr1 = 4'h4; left1 = 1; req1 = 1;
`ifdef EEPROM_ARB_TIMEOUT_EN
    wait_acks(9, 100);
    chk("to_err", ack_err, 1);
    chk("to_rdata_kept", ack_rd, 8'hC3);
    chk("to_go_to_ack", ack_cyc - go_cyc, 17);
    chk("to_port", order[8], 1);
    stray = 1;
    repeat (4) tick();
    chk("to_late_done_busy", busy, 0);
    chk("to_late_done_acks", n_ack, 9);
`else
    repeat (200) tick();
    chk("hang_busy", busy, 1);
    chk("hang_acks", n_ack, 8);
    left1 = 0; req1 = 0; reset_n = 0;
    tick();
    reset_n = 1;
    tick();
    chk("hang_cleared", busy, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
